control_sequencer: RTL

- Fetch/execute micro-sequencer for the 8-bit single-bus CPU.
- Sits directly upstream of every bus register. It drives their write enables and bus-drive enables, so each bus transfer is one register output onto the bus and one or more register loads from it.
- Reads the opcode from the instruction register's dedicated output and reads the carry and zero flags.
- Generates one micro-step per clock.

---
 rtl/control_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Fetch/execute micro-sequencer for the 8-bit single-bus CPU.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_step_en,
   input  logic [DATA_WIDTH-1:0] i_instr,
   input  logic                  i_flag_c,
   input  logic                  i_flag_z,
   output logic                  o_pc_oe,
   output logic                  o_pc_inc,
   output logic                  o_pc_we,
   output logic                  o_mar_we,
   output logic                  o_ram_oe,
   output logic                  o_ram_we,
   output logic                  o_ir_we,
   output logic                  o_ir_oe,
   output logic                  o_a_we,
   output logic                  o_a_oe,
   output logic                  o_b_we,
   output logic                  o_alu_oe,
   output logic                  o_alu_sub,
   output logic                  o_flags_we,
   output logic                  o_out_we,
   output logic                  o_halt,
   output logic [2:0]            o_step
);

   localparam logic [OPCODE_WIDTH-1:0] c_OP_LDA = OPCODE_WIDTH'(4'h1);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_ADD = OPCODE_WIDTH'(4'h2);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_SUB = OPCODE_WIDTH'(4'h3);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_STA = OPCODE_WIDTH'(4'h4);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_LDI = OPCODE_WIDTH'(4'h5);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_JMP = OPCODE_WIDTH'(4'h6);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_JC  = OPCODE_WIDTH'(4'h7);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_JZ  = OPCODE_WIDTH'(4'h8);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_OUT = OPCODE_WIDTH'(4'hE);
   localparam logic [OPCODE_WIDTH-1:0] c_OP_HLT = OPCODE_WIDTH'(4'hF);

   typedef enum logic [2:0] {
      S_T0   = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [OPCODE_WIDTH-1:0] w_opcode;
   logic                    w_unused_operand;
   logic                    w_gate;

   logic w_pc_oe, w_pc_inc, w_pc_we, w_mar_we, w_ram_oe, w_ram_we, w_ir_we;
   logic w_ir_oe, w_a_we, w_a_oe, w_b_we, w_alu_oe, w_alu_sub, w_flags_we;
   logic w_out_we;

   assign w_opcode         = i_instr[DATA_WIDTH-1 -: OPCODE_WIDTH];
   assign w_unused_operand = ^i_instr[DATA_WIDTH-OPCODE_WIDTH-1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_T0;
      end else if (i_step_en) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      w_pc_oe    = 1'b0;
      w_pc_inc   = 1'b0;
      w_pc_we    = 1'b0;
      w_mar_we   = 1'b0;
      w_ram_oe   = 1'b0;
      w_ram_we   = 1'b0;
      w_ir_we    = 1'b0;
      w_ir_oe    = 1'b0;
      w_a_we     = 1'b0;
      w_a_oe     = 1'b0;
      w_b_we     = 1'b0;
      w_alu_oe   = 1'b0;
      w_alu_sub  = 1'b0;
      w_flags_we = 1'b0;
      w_out_we   = 1'b0;

      case (state_q)
         S_T0: begin
            w_pc_oe  = 1'b1;
            w_mar_we = 1'b1;
            state_d  = S_T1;
         end
         S_T1: begin
            w_ram_oe = 1'b1;
            w_ir_we  = 1'b1;
            w_pc_inc = 1'b1;
            state_d  = S_T2;
         end
         S_T2: begin
            state_d = S_T0;
            case (w_opcode)
               c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                  w_ir_oe  = 1'b1;
                  w_mar_we = 1'b1;
                  state_d  = S_T3;
               end
               c_OP_LDI: begin
                  w_ir_oe = 1'b1;
                  w_a_we  = 1'b1;
               end
               c_OP_JMP: begin
                  w_ir_oe = 1'b1;
                  w_pc_we = 1'b1;
               end
               c_OP_JC: begin
                  w_ir_oe = i_flag_c;
                  w_pc_we = i_flag_c;
               end
               c_OP_JZ: begin
                  w_ir_oe = i_flag_z;
                  w_pc_we = i_flag_z;
               end
               c_OP_OUT: begin
                  w_a_oe   = 1'b1;
                  w_out_we = 1'b1;
               end
               c_OP_HLT: begin
                  state_d = S_HALT;
               end
               default: begin
               end
            endcase
         end
         S_T3: begin
            state_d = S_T0;
            case (w_opcode)
               c_OP_LDA: begin
                  w_ram_oe = 1'b1;
                  w_a_we   = 1'b1;
               end
               c_OP_ADD, c_OP_SUB: begin
                  w_ram_oe  = 1'b1;
                  w_b_we    = 1'b1;
                  w_alu_sub = (w_opcode == c_OP_SUB);
                  state_d   = S_T4;
               end
               c_OP_STA: begin
                  w_a_oe   = 1'b1;
                  w_ram_we = 1'b1;
               end
               default: begin
               end
            endcase
         end
         S_T4: begin
            state_d = S_T0;
            if ((w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB)) begin
               w_alu_oe   = 1'b1;
               w_a_we     = 1'b1;
               w_flags_we = 1'b1;
               w_alu_sub  = (w_opcode == c_OP_SUB);
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_T0;
         end
      endcase
   end

   // Frozen or resetting sequencer must not re-fire any write or bus drive.
   assign w_gate = i_step_en & ~i_rst;

   assign o_pc_oe    = w_gate & w_pc_oe;
   assign o_pc_inc   = w_gate & w_pc_inc;
   assign o_pc_we    = w_gate & w_pc_we;
   assign o_mar_we   = w_gate & w_mar_we;
   assign o_ram_oe   = w_gate & w_ram_oe;
   assign o_ram_we   = w_gate & w_ram_we;
   assign o_ir_we    = w_gate & w_ir_we;
   assign o_ir_oe    = w_gate & w_ir_oe;
   assign o_a_we     = w_gate & w_a_we;
   assign o_a_oe     = w_gate & w_a_oe;
   assign o_b_we     = w_gate & w_b_we;
   assign o_alu_oe   = w_gate & w_alu_oe;
   assign o_alu_sub  = w_gate & w_alu_sub;
   assign o_flags_we = w_gate & w_flags_we;
   assign o_out_we   = w_gate & w_out_we;

   assign o_halt = (state_q == S_HALT) & ~i_rst;
   assign o_step = (state_q == S_HALT) ? 3'd0 : 3'(state_q);

endmodule

`default_nettype wire
